// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART transmit arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Arbiter controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // 1 launch tick + 16 start + 128 data + 16 stop at 16x oversampling.
  localparam int FRAME_TICKS_DEFAULT = 161;
  localparam int BAUD_OVERSAMPLE     = 16;
  localparam int DATA_BITS           = 8;

  // Larger of two integers, used for sizing the shared tick counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Grants the first requester at
//            or after i_ptr, wrapping modulo NUM_REQ.
//            With UART_TX_ARB_PRIORITY_EN defined, requester 0 wins whenever
//            it requests; the rest keep rotating among themselves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any_req
);

  logic [NUM_REQ-1:0] w_req;
  logic               w_found;
  logic [IDX_W-1:0]   w_sel;
  int                 w_idx;

  // Scan from the pointer forward and pick the first live request.
  always_comb begin
    w_req   = i_enable ? i_req : '0;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
`ifdef UART_TX_ARB_PRIORITY_EN
    // Requester 0 pre-empts the rotation; the scan below then finds nothing
    // new because w_found is already set.
    if (w_req[0]) begin
      o_grant[0] = 1'b1;
      w_found    = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      w_sel = IDX_W'(w_idx);
      if (!w_found && w_req[w_sel]) begin
        o_grant[w_sel] = 1'b1;
        o_idx          = w_sel;
        w_found        = 1'b1;
      end
    end
    o_any_req = |w_req;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter between NUM_REQ byte requesters.
//            One byte per grant; tx_en is held for FRAME_TICKS baud ticks,
//            then an idle gap of GAP_TICKS ticks precedes the next grant.
// Options  : UART_TX_ARB_PRIORITY_EN - requester 0 gets strict priority and
//            does not advance the round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_TICKS = FRAME_TICKS_DEFAULT,
  parameter int GAP_TICKS   = 16,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         enable,
  input  logic                         baud_tick,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_en,
  output logic [DATA_BITS-1:0]         tx_data,
  output logic [IDX_W-1:0]             grant_id,
  output logic                         busy
);

  localparam int CNT_W = $clog2(max_int(FRAME_TICKS, GAP_TICKS) + 1);
  localparam logic [CNT_W-1:0] c_frame_last = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] c_gap_last   = (GAP_TICKS > 0) ? CNT_W'(GAP_TICKS - 1) : '0;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_ptr;
  logic [DATA_BITS-1:0]  r_tx_data;
  logic [IDX_W-1:0]      r_grant_id;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_any;
  logic [IDX_W-1:0]      w_ptr_next;
  logic [DATA_BITS-1:0]  w_sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .i_enable  (enable),
    .o_grant   (w_grant),
    .o_idx     (w_gnt_idx),
    .o_any_req (w_any)
  );

  // Byte lanes are 8 bits wide, so the lane offset is the index shifted by 3.
  assign w_sel_data = req_data[{w_gnt_idx, 3'b000} +: DATA_BITS];
  assign w_ptr_next = (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: grant leaves IDLE, the last tick of each phase moves on.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next_state = SEND;
        end
      end
      SEND: begin
        if (baud_tick && (r_cnt == c_frame_last)) begin
          w_next_state = (GAP_TICKS > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (baud_tick && (r_cnt == c_gap_last)) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Tick counter, pointer and latched grant; a tick on the grant edge is ignored.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_tx_data  <= '0;
      r_grant_id <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_cnt      <= '0;
            r_tx_data  <= w_sel_data;
            r_grant_id <= w_gnt_idx;
`ifdef UART_TX_ARB_PRIORITY_EN
            // A priority grant to requester 0 leaves the rotation untouched.
            if (!w_grant[0]) begin
              r_ptr <= w_ptr_next;
            end
`else
            r_ptr <= w_ptr_next;
`endif
          end
        end
        SEND: begin
          if (baud_tick) begin
            r_cnt <= (r_cnt == c_frame_last) ? '0 : r_cnt + 1'b1;
          end
        end
        GAP: begin
          if (baud_tick) begin
            r_cnt <= (r_cnt == c_gap_last) ? '0 : r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Outputs decode from the state register so reset drops them at once.
  always_comb begin
    tx_en     = (r_state == SEND);
    busy      = (r_state != IDLE);
    req_ready = ((r_state == IDLE) && !arst) ? w_grant : '0;
    tx_data   = r_tx_data;
    grant_id  = r_grant_id;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter (defaults:
//            4 requesters, 161-tick frame, 16-tick gap).
// Options  : UART_TX_ARB_PRIORITY_EN selects the priority scenario instead of
//            the round-robin fairness scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic        enable;
  logic        baud_tick;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int send_ticks = 0;
  int gap_ticks  = 0;
  int bad_rdy    = 0;

  uart_tx_arbiter #(
    .NUM_REQ     (4),
    .FRAME_TICKS (161),
    .GAP_TICKS   (16)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .enable    (enable),
    .baud_tick (baud_tick),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One baud tick every third clock, changed just after the rising edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (2) begin
        @(posedge clk);
        #1 baud_tick = 1'b0;
      end
      @(posedge clk);
      #1 baud_tick = 1'b1;
    end
  end

  // Observe on the falling edge: tick counts per phase, illegal ready pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (baud_tick && tx_en) send_ticks++;
      if (baud_tick && busy && !tx_en) gap_ticks++;
      if (req_ready != 4'b0 && (busy || tx_en || !$onehot(req_ready))) bad_rdy++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic apply_reset();
    arst      = 1'b1;
    req_valid = 4'b0;
    enable    = 1'b1;
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
  endtask

  // Wait (bounded) for the next req_ready pulse; returns at that falling edge.
  task automatic wait_ready(input string tag, output logic [3:0] r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 4'b0 && n < 3000);
    r = req_ready;
    if (r == 4'b0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Wait (bounded) until busy falls.
  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    if (busy) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    logic [3:0] r;
    int s0;
    int g0;
    int n;
    logic [3:0] exp_r;

    req_data = 32'h0;
    apply_reset();
    arst = 1'b1;
    #2;
    check("rst_tx_en",     {31'd0, tx_en}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_ready",     {28'd0, req_ready}, 32'd0);
    check("rst_tx_data",   {24'd0, tx_data}, 32'd0);
    check("rst_grant_id",  {30'd0, grant_id}, 32'd0);
    @(posedge clk);
    #1 arst = 1'b0;

    // ---- Single request ----
    req_data  = 32'h00A5_0000;
    req_valid = 4'b0100;
    wait_ready("single", r);
    check("single_ready", {28'd0, r}, 32'h4);
    s0 = send_ticks;
    g0 = gap_ticks;
    @(posedge clk);
    #1 req_valid = 4'b0;
    @(negedge clk);
    check("single_pulse_1cyc", {28'd0, req_ready}, 32'd0);
    check("single_tx_en",      {31'd0, tx_en}, 32'd1);
    check("single_tx_data",    {24'd0, tx_data}, 32'hA5);
    check("single_grant_id",   {30'd0, grant_id}, 32'd2);
    check("single_busy",       {31'd0, busy}, 32'd1);
    wait_idle("single");
    check("single_send_ticks", send_ticks - s0, 32'd161);
    check("single_gap_ticks",  gap_ticks - g0, 32'd16);
    check("single_idle_tx_en", {31'd0, tx_en}, 32'd0);
    check("single_hold_data",  {24'd0, tx_data}, 32'hA5);

`ifndef UART_TX_ARB_PRIORITY_EN
    // ---- Round-robin fairness ----
    apply_reset();
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ready("rr", r);
      exp_r = 4'b0001 << (i % 4);
      check("rr_order", {28'd0, r}, {28'd0, exp_r});
      @(negedge clk);
      check("rr_tx_data",  {24'd0, tx_data}, 32'h10 + (i % 4));
      check("rr_grant_id", {30'd0, grant_id}, i % 4);
    end
`else
    // ---- Strict priority for requester 0 ----
    apply_reset();
    req_data  = 32'h0022_0011;
    req_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      wait_ready("prio", r);
      check("prio_req0", {28'd0, r}, 32'h1);
    end
    @(posedge clk);
    #1 req_valid = 4'b0100;
    wait_ready("prio_drop", r);
    check("prio_req2", {28'd0, r}, 32'h4);
    @(negedge clk);
    check("prio_tx_data", {24'd0, tx_data}, 32'h22);
`endif

    // ---- Pointer wrap: pointer=3 after granting 2, then {1,3} valid ----
    apply_reset();
    req_data  = 32'h3300_1100;
    req_valid = 4'b0100;
    wait_ready("wrap_pre", r);
    check("wrap_pre", {28'd0, r}, 32'h4);
    @(posedge clk);
    #1 req_valid = 4'b1010;
    wait_ready("wrap1", r);
    check("wrap_g3a", {28'd0, r}, 32'h8);
    wait_ready("wrap2", r);
    check("wrap_g1", {28'd0, r}, 32'h2);
    wait_ready("wrap3", r);
    check("wrap_g3b", {28'd0, r}, 32'h8);
    @(negedge clk);
    check("wrap_tx_data", {24'd0, tx_data}, 32'h33);

    // ---- Enable gating ----
    apply_reset();
    req_data  = 32'h0000_775A;
    req_valid = 4'b0001;
    wait_ready("en", r);
    check("en_first", {28'd0, r}, 32'h1);
    s0 = send_ticks;
    @(posedge clk);
    #1 req_valid = 4'b0010;
    repeat (30) @(posedge clk);
    #1 enable = 1'b0;
    wait_idle("en");
    check("en_send_ticks", send_ticks - s0, 32'd161);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_ready != 4'b0 || tx_en) n++;
    end
    check("en_no_grant", n, 32'd0);
    @(posedge clk);
    #1 enable = 1'b1;
    @(negedge clk);
    check("en_ready", {28'd0, req_ready}, 32'h2);
    @(negedge clk);
    check("en_tx_en",    {31'd0, tx_en}, 32'd1);
    check("en_grant_id", {30'd0, grant_id}, 32'd1);
    check("en_tx_data",  {24'd0, tx_data}, 32'h77);

    // ---- Reset mid-frame ----
    apply_reset();
    req_data  = 32'h4433_2211;
    req_valid = 4'b0100;
    wait_ready("mid", r);
    @(posedge clk);
    #1 req_valid = 4'b0;
    s0 = send_ticks;
    n = 0;
    while ((send_ticks - s0) < 50 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached_50", {31'd0, tx_en}, 32'd1);
    #2 arst = 1'b1;
    #1;
    check("mid_tx_en",    {31'd0, tx_en}, 32'd0);
    check("mid_busy",     {31'd0, busy}, 32'd0);
    check("mid_ready",    {28'd0, req_ready}, 32'd0);
    check("mid_grant_id", {30'd0, grant_id}, 32'd0);
    req_valid = 4'b1111;
    @(posedge clk);
    #1 arst = 1'b0;
    wait_ready("mid_after", r);
    check("mid_after_req0", {28'd0, r}, 32'h1);
    @(negedge clk);
    check("mid_after_data", {24'd0, tx_data}, 32'h11);
    req_valid = 4'b0;

    check("no_ready_while_busy", bad_rdy, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Accepts one byte per grant over a valid/ready handshake and latches it onto tx_data.
- Holds tx_en high for a fixed number of baud ticks (one full frame), then enforces an idle gap before the next grant.
- Sits between the requesting clients and the transmitter's en/data_in/baud_tick inputs.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- FRAME_TICKS, 161: baud ticks tx_en is held high per byte (1 launch tick + 16 start + 128 data + 16 stop).
- GAP_TICKS, 16: baud ticks tx_en is held low between frames; 0 means no gap.

Ports:
- clk  in  1  system clock.
- arst  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new grants are issued; a frame already in progress completes.
- baud_tick  in  1  one-cycle strobe from the baud generator.
- req_valid  in  NUM_REQ  per-requester byte-available flag.
- req_data  in  NUM_REQ*8  packed bytes; requester i occupies bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot, one-cycle pulse that accepts the byte.
- tx_en  out  1  transmitter enable.
- tx_data  out  8  byte presented to the transmitter.
- grant_id  out  clog2(NUM_REQ)  index of the requester last granted.
- busy  out  1  high in SEND and GAP.

Behaviour:
- Reset (async, arst=1):
  - state=IDLE; tick counter=0; round-robin pointer=0.
  - tx_en=0, tx_data=0, req_ready=0, grant_id=0, busy=0.
  - Reset asserted mid-frame drops tx_en immediately. The transmitter returns to idle-high because its en is low.
- States: IDLE, SEND, GAP (2-bit encoding).
- IDLE:
  - If enable=1 and any req_valid is high, a grant g is chosen combinationally: the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - In that same cycle req_ready[g]=1 (exactly one bit).
  - On the next edge: tx_data<=req_data[g], grant_id<=g, pointer<=(g+1) mod NUM_REQ, counter<=0, state<=SEND.
  - tx_en goes high one cycle after the req_ready pulse.
- SEND:
  - tx_en=1. The counter increments on each baud_tick.
  - On the baud_tick where counter==FRAME_TICKS-1: counter<=0, and state<=GAP (GAP_TICKS>0) or IDLE (GAP_TICKS==0).
  - tx_en is low starting the cycle after that tick.
- GAP:
  - tx_en=0. The counter increments on each baud_tick.
  - On the tick where counter==GAP_TICKS-1, state<=IDLE.
- Handshake rules:
  - A requester must hold req_valid and req_data stable until it sees req_ready.
  - req_valid deasserted without a ready is legal; that requester is simply skipped.
  - req_ready is never asserted outside IDLE.
- enable:
  - Sampled only in IDLE. enable=0 in SEND or GAP has no effect.
  - With enable=0 in IDLE, req_ready stays 0 and tx_en stays 0.
- Simultaneous events: a baud_tick coinciding with a grant cycle is not counted. The counter starts from the first tick after entry to SEND.
- Counter width: clog2(max(FRAME_TICKS, GAP_TICKS)+1). There is no wrap inside a state.
- tx_data and grant_id hold their values until the next grant.

Optional Feature:
- Macro: UART_TX_ARB_PRIORITY_EN.
- Defined: requester 0 has strict priority. Whenever req_valid[0]=1 in IDLE, it is granted and the pointer is not updated. Requesters 1..NUM_REQ-1 round-robin among themselves when req_valid[0]=0.
- Undefined: pure round-robin over all requesters, as described above.

Decomposition:
- Package uart_pkg: state enum (IDLE/SEND/GAP), FRAME_TICKS_DEFAULT=161, BAUD_OVERSAMPLE=16, DATA_BITS=8.
- One natural sub-module: rr_arbiter.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, encoded index, any_req.
  - Combinational; the priority variant is selected inside it by the macro.
  - Instantiated once.

Test Plan:
- Single request:
  - Stimulus: reset, enable=1, req_valid=4'b0100, req_data[2]=8'hA5.
  - Response: req_ready=4'b0100 for 1 cycle; tx_data=8'hA5; grant_id=2; tx_en high for exactly 161 baud ticks, then low for 16 ticks; busy falls as IDLE is re-entered.
- Round-robin fairness:
  - Stimulus: all four valid continuously, distinct bytes 8'h10..8'h13.
  - Response: grant order 0,1,2,3,0; no req_ready pulse during SEND or GAP.
- Pointer wrap:
  - Stimulus: pointer=3, then only req 1 and req 3 valid.
  - Response: grant 3, then 1, then 3.
- Enable gating:
  - Stimulus: drop enable mid-SEND.
  - Response: frame finishes the full 161 ticks; no grant occurs while enable=0; a grant occurs 1 cycle after enable returns high.
- Reset mid-frame:
  - Stimulus: assert arst at tick 50 of SEND.
  - Response: tx_en=0, req_ready=0, busy=0 asynchronously; after release the pointer=0, so req 0 is granted first.
- Priority variant (UART_TX_ARB_PRIORITY_EN defined):
  - Stimulus: reqs 0 and 2 continuously valid.
  - Response: req 0 is granted every frame and req 2 never. Once req 0 drops, req 2 is granted.
